ifq_fetch_unit: RTL
===================

Name: ifq_fetch_unit

Overview:
- Instruction fetch queue at the consumer end of the jump/branch address path.
- Holds the fetch PC, issues single-outstanding reads to the I-cache, and buffers returned instructions with their PC+4 for dispatch.
- Accepts the combinational jump/branch redirect from dispatch, then flushes and refetches from the new target.
- PC+4 is computed here, not by the address logic.

Parameters:
- DEPTH, 4, number of queue entries (power of 2, min 2).
- RESET_PC, 32'h00000000, fetch PC after reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- redirect_valid  input  1  jump/branch taken this cycle.
- jmp_branch_address  input  32  redirect target; sampled when redirect_valid=1.
- icache_rd_en  output  1  fetch request strobe, one cycle per request.
- icache_addr  output  32  fetch address; valid while icache_rd_en=1.
- icache_valid  input  1  response strobe for the outstanding request.
- icache_data  input  32  instruction word; valid with icache_valid.
- ifq_rd_en  input  1  dispatch dequeues head entry; ignored when ifq_empty=1.
- inst_out  output  32  head instruction.
- pc_plus4_out  output  32  head entry's fetch address + 4.
- ifq_empty  output  1  queue holds no entries.
- ifq_full  output  1  count == DEPTH.

Behaviour:
- Reset values: fetch_pc=RESET_PC, count=0, state=FETCH, icache_rd_en=0, icache_addr=0, inst_out=0, pc_plus4_out=0, ifq_empty=1, ifq_full=0.
- Queue:
  - Circular buffer with wr_ptr/rd_ptr of log2(DEPTH) bits that wrap naturally, plus a count of log2(DEPTH)+1 bits.
  - Each entry stores {instruction, fetch_addr+4}. Addition is mod 2^32, so 32'hFFFFFFFC yields 0.
  - inst_out and pc_plus4_out show the head combinationally; they are 0 when empty.
- FSM states: FETCH, WAIT, DROP.
  - FETCH: if count<DEPTH and no redirect, drive icache_rd_en=1, icache_addr=fetch_pc; fetch_pc<=fetch_pc+4; go WAIT. Otherwise stay, with icache_rd_en=0.
  - WAIT: on icache_valid, write {icache_data, req_addr+4} and go FETCH. req_addr is the latched icache_addr.
  - DROP: an in-flight response must be discarded. On icache_valid, drop the data and go FETCH.
- Throughput: a request issues in cycle N, the response arrives no earlier than N+1, and the next request goes out the cycle after the response. Peak rate is 1 instruction per 2 cycles.
- Simultaneous write and read in the same cycle: count unchanged. A read never returns the word written that cycle, because there is no bypass.
- Full: no request issues. The single outstanding request was checked against count<DEPTH at issue, so WAIT can never overflow.
- Redirect (redirect_valid=1), highest priority:
  - Flush: rd_ptr=wr_ptr=count=0, and fetch_pc<=jmp_branch_address.
  - Next state:
    - From FETCH: stay FETCH with no request that cycle; the first new request goes out the next cycle.
    - From WAIT: go DROP. If icache_valid is also asserted that cycle, discard the word and go FETCH instead.
    - From DROP: stay DROP with the updated PC. If icache_valid is also asserted that cycle, go FETCH.
  - Redirect with ifq_rd_en in the same cycle: the flush wins, and ifq_empty=1 the next cycle.
- ifq_rd_en while empty: no pointer or count change.
- rst asserted mid-operation: immediate return to reset values. Any I-cache response arriving after reset release is ignored, because state is FETCH and no request is outstanding.
- icache_valid in FETCH: ignored.

Optional Feature:
- Macro: IFQ_FLUSH_CNT_EN.
- Defined:
  - Adds output flush_count [15:0], reset to 0.
  - Increments once per cycle with redirect_valid=1 and saturates at 16'hFFFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release, I-cache responding 1 cycle after each request with data=addr^32'hA5A5A5A5 -> requests to 0x0, 0x4, 0x8, 0xC on alternating cycles. Head shows inst 0xA5A5A5A5 and pc_plus4_out 0x4. After 4 fills with no reads: ifq_full=1, no further icache_rd_en.
- Full queue, then ifq_rd_en for 1 cycle -> count=3, ifq_full=0; the next request goes to 0x10 the following cycle.
- Redirect to 0x00400100 in WAIT, response 2 cycles later -> that response is dropped, and the next request goes to 0x00400100. The first entry after that has pc_plus4_out=0x00400104.
- Redirect and icache_valid in the same WAIT cycle, with ifq_rd_en also high -> word discarded, ifq_empty=1 next cycle, and the next request goes to the target.
- Fetch at 0xFFFFFFFC -> entry pc_plus4_out=0x00000000, and the next request goes to 0x00000000.
- rst low while in WAIT with 2 entries queued -> ifq_empty=1 and icache_rd_en=0 immediately. A late icache_valid after release is not written, and the first request goes to RESET_PC. With IFQ_FLUSH_CNT_EN defined, 3 redirects give flush_count=3.

Source files
------------

// File: rtl/ifq_fetch_unit.sv
// Instruction fetch queue: single-outstanding I-cache fetch, DEPTH-entry {inst, pc+4} buffer, redirect flush.
// Optional macro IFQ_FLUSH_CNT_EN adds a saturating 16-bit flush_count output.
module ifq_fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] jmp_branch_address,
    output logic        icache_rd_en,
    output logic [31:0] icache_addr,
    input  logic        icache_valid,
    input  logic [31:0] icache_data,
    input  logic        ifq_rd_en,
    output logic [31:0] inst_out,
    output logic [31:0] pc_plus4_out,
    output logic        ifq_empty,
    output logic        ifq_full
`ifdef IFQ_FLUSH_CNT_EN
    ,
    output logic [15:0] flush_count
`endif
);

    localparam int               PTR_W     = $clog2(DEPTH);
    localparam logic [PTR_W:0]   L_DEPTH   = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   L_CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] L_PTR_ONE = PTR_W'(1);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t           r_state;
    logic [31:0]      r_fetch_pc;
    logic [31:0]      r_req_addr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [63:0]      r_mem [DEPTH];

    logic        w_empty;
    logic        w_full;
    logic        w_issue;
    logic        w_wr;
    logic        w_rd;
    logic [63:0] w_head;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == L_DEPTH);

    // Request is combinational from FETCH so a response-then-request pair costs only 2 cycles;
    // gating with rst keeps the strobe low while reset is held.
    assign w_issue = rst && (r_state == S_FETCH) && !w_full && !redirect_valid;
    assign w_wr    = (r_state == S_WAIT) && icache_valid && !redirect_valid;
    assign w_rd    = ifq_rd_en && !w_empty && !redirect_valid;

    assign icache_rd_en = w_issue;
    assign icache_addr  = w_issue ? r_fetch_pc : 32'h0;

    assign w_head       = r_mem[r_rd_ptr];
    assign inst_out     = w_empty ? 32'h0 : w_head[63:32];
    assign pc_plus4_out = w_empty ? 32'h0 : w_head[31:0];
    assign ifq_empty    = w_empty;
    assign ifq_full     = w_full;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_FETCH;
            r_fetch_pc <= RESET_PC;
            r_req_addr <= 32'h0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else if (redirect_valid) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_fetch_pc <= jmp_branch_address;
            if (r_state == S_FETCH) begin
                r_state <= S_FETCH;
            end else begin
                r_state <= icache_valid ? S_FETCH : S_DROP;
            end
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + L_PTR_ONE;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + L_PTR_ONE;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + L_CNT_ONE;
                2'b01:   r_count <= r_count - L_CNT_ONE;
                default: r_count <= r_count;
            endcase

            case (r_state)
                S_FETCH: begin
                    if (w_issue) begin
                        r_req_addr <= r_fetch_pc;
                        r_fetch_pc <= r_fetch_pc + 32'd4;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (icache_valid) begin
                        r_state <= S_FETCH;
                    end
                end
                S_DROP: begin
                    if (icache_valid) begin
                        r_state <= S_FETCH;
                    end
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // NOTE: queue storage has no reset; count and pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {icache_data, r_req_addr + 32'd4};
        end
    end

`ifdef IFQ_FLUSH_CNT_EN
    logic [15:0] r_flush_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flush_count <= 16'h0;
        end else if (redirect_valid && (r_flush_count != 16'hFFFF)) begin
            r_flush_count <= r_flush_count + 16'd1;
        end
    end

    assign flush_count = r_flush_count;
`endif

endmodule
